// File: rtl/f68k_bus_pkg.sv
// rtl/f68k_bus_pkg.sv - shared 68000 bus-side encodings for responder and watchdog
package f68k_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RELEASE = 2'd3
   } bus_state_t;

   localparam logic [2:0] FC_INTACK = 3'b111;

   // 68000 strobes are active-low
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/dtack_responder_sync2.sv
// rtl/dtack_responder_sync2.sv - two-flop synchroniser, resets to 1 (strobe negated)
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dtack_responder.sv
// rtl/dtack_responder.sv - 68000 DTACK responder with wait states and watchdog clear
// Optional interrupt-acknowledge VPA response: DTACK_RESPONDER_VPA_EN
module dtack_responder
   import f68k_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       as_n,
   input  logic       uds_n,
   input  logic       lds_n,
   input  logic       rw,
   input  logic       sel,
   input  logic [2:0] fc,
   output logic       dtack_n,
   output logic       clr,
   output logic       dev_req,
   output logic       dev_we,
   output logic [1:0] dev_be,
   output logic       vpa_n
);

   generate
      if (WAIT_CYCLES >= (1 << CNT_W)) begin : g_cfg_err
         $error("dtack_responder: WAIT_CYCLES does not fit in CNT_W bits");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic as_s, uds_s, lds_s;

   sync2 u_sync_as  (.clk(clk), .rst_n(rst_n), .d(as_n),  .q(as_s));
   sync2 u_sync_uds (.clk(clk), .rst_n(rst_n), .d(uds_n), .q(uds_s));
   sync2 u_sync_lds (.clk(clk), .rst_n(rst_n), .d(lds_n), .q(lds_s));

   bus_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dtack_n_q, dtack_n_d;
   logic             clr_q, clr_d;
   logic             dev_req_q, dev_req_d;
   logic             dev_we_q, dev_we_d;
   logic [1:0]       dev_be_q, dev_be_d;
   logic             start;
   logic             ack_d;
`ifdef DTACK_RESPONDER_VPA_EN
   logic             iack_q, iack_d;
   logic             vpa_n_q, vpa_n_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dev_we_d = dev_we_q;
      dev_be_d = dev_be_q;
`ifdef DTACK_RESPONDER_VPA_EN
      iack_d   = iack_q;
`endif
      start = (as_s == STROBE_ON) && ((uds_s == STROBE_ON) || (lds_s == STROBE_ON)) && sel;

      case (state_q)
         IDLE: begin
            // sel/rw/fc are only looked at here; ownership is fixed for the whole cycle
            if (start) begin
               dev_we_d = ~rw;
               dev_be_d = {uds_s == STROBE_ON, lds_s == STROBE_ON};
               cnt_d    = '0;
`ifdef DTACK_RESPONDER_VPA_EN
               iack_d   = (fc == FC_INTACK);
`endif
               state_d  = (WAIT_CYCLES == 0) ? ACK : WAIT;
            end
         end
         WAIT: begin
            if (as_s == STROBE_OFF) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ACK;
            end
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACK: begin
            if (as_s == STROBE_OFF) begin
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet aligned with it
      ack_d     = (state_d == ACK);
      clr_d     = ack_d && (state_q != ACK);
      dev_req_d = (state_d == WAIT) || (state_d == ACK);
`ifdef DTACK_RESPONDER_VPA_EN
      dtack_n_d = !(ack_d && !iack_d);
      vpa_n_d   = !(ack_d && iack_d);
`else
      dtack_n_d = !ack_d;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dtack_n_q <= 1'b1;
         clr_q     <= 1'b0;
         dev_req_q <= 1'b0;
         dev_we_q  <= 1'b0;
         dev_be_q  <= 2'b00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dtack_n_q <= dtack_n_d;
         clr_q     <= clr_d;
         dev_req_q <= dev_req_d;
         dev_we_q  <= dev_we_d;
         dev_be_q  <= dev_be_d;
      end
   end

`ifdef DTACK_RESPONDER_VPA_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iack_q  <= 1'b0;
         vpa_n_q <= 1'b1;
      end else begin
         iack_q  <= iack_d;
         vpa_n_q <= vpa_n_d;
      end
   end

   assign vpa_n = vpa_n_q;
`else
   logic unused_fc;
   assign unused_fc = ^fc;
   assign vpa_n     = 1'b1;
`endif

   assign dtack_n = dtack_n_q;
   assign clr     = clr_q;
   assign dev_req = dev_req_q;
   assign dev_we  = dev_we_q;
   assign dev_be  = dev_be_q;

endmodule

// File: tb/tb_dtack_responder.sv
// tb/tb_dtack_responder.sv - directed bench for dtack_responder at WAIT_CYCLES 2, 0 and 5
module tb_dtack_responder;

   logic       clk;
   logic       rst_n;
   logic       as_n, uds_n, lds_n, rw, sel;
   logic [2:0] fc;

   logic       dtack_n2, clr2, req2, we2, vpa2;
   logic [1:0] be2;
   logic       dtack_n0, clr0, req0, we0, vpa0;
   logic [1:0] be0;
   logic       dtack_n5, clr5, req5, we5, vpa5;
   logic [1:0] be5;

   int errors = 0;
   int checks = 0;

   dtack_responder #(.WAIT_CYCLES(2), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
      .rw(rw), .sel(sel), .fc(fc), .dtack_n(dtack_n2), .clr(clr2),
      .dev_req(req2), .dev_we(we2), .dev_be(be2), .vpa_n(vpa2));

   dtack_responder #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
      .rw(rw), .sel(sel), .fc(fc), .dtack_n(dtack_n0), .clr(clr0),
      .dev_req(req0), .dev_we(we0), .dev_be(be0), .vpa_n(vpa0));

   dtack_responder #(.WAIT_CYCLES(5), .CNT_W(4)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
      .rw(rw), .sel(sel), .fc(fc), .dtack_n(dtack_n5), .clr(clr5),
      .dev_req(req5), .dev_we(we5), .dev_be(be5), .vpa_n(vpa5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      rw    = 1'b1;
      sel   = 1'b0;
      fc    = 3'b000;
   endtask

   initial begin
      int clr_cnt;
      int bad;
      logic exp_lo;

      rst_n = 1'b0;
      bus_idle();
      tick();
      tick();
      chk("rst_dtack_n", dtack_n2, 1);
      chk("rst_clr", clr2, 0);
      chk("rst_dev_req", req2, 0);
      chk("rst_dev_we", we2, 0);
      chk("rst_dev_be", be2, 2'b00);
      chk("rst_vpa_n", vpa2, 1);
      rst_n = 1'b1;
      tick();
      tick();

      // Read cycle, all strobes together; AS negated after clock 7
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("rd_dtack_w2", dtack_n2, (k >= 5 && k <= 9) ? 0 : 1);
         chk("rd_clr_w2", clr2, (k == 5) ? 1 : 0);
         chk("rd_dtack_w0", dtack_n0, (k >= 3 && k <= 9) ? 0 : 1);
         chk("rd_dtack_w5", dtack_n5, (k >= 8 && k <= 9) ? 0 : 1);
         if (k == 2) chk("rd_req_early", req2, 0);
         if (k == 3) begin
            chk("rd_req", req2, 1);
            chk("rd_be", be2, 2'b11);
            chk("rd_we", we2, 0);
         end
         if (k == 10) chk("rd_req_release", req2, 0);
         if (k == 7) bus_idle();
      end
      tick(); tick(); tick();

      // Write, lower byte only, DS two clocks after AS
      as_n = 1'b0; rw = 1'b0; sel = 1'b1;
      clr_cnt = 0;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (clr2) clr_cnt++;
         chk("wr_dtack_w2", dtack_n2, (k >= 7 && k <= 11) ? 0 : 1);
         if (k == 4) chk("wr_req_before_ds", req2, 0);
         if (k == 5) begin
            chk("wr_req", req2, 1);
            chk("wr_we", we2, 1);
            chk("wr_be", be2, 2'b01);
         end
         if (k == 2) lds_n = 1'b0;
         if (k == 9) bus_idle();
      end
      chk("wr_clr_count", clr_cnt, 1);
      tick(); tick(); tick();

      // Unselected cycle held for 300 clocks: nothing may respond
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b0;
      bad = 0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (!dtack_n2 || clr2 || req2 || !dtack_n0 || clr0 || req0 || !dtack_n5 || clr5 || req5)
            bad++;
      end
      chk("nosel_idle", bad, 0);
      bus_idle();
      tick(); tick(); tick();

      // Abort during WAIT of the 5-wait-state instance
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1;
      bad = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (!dtack_n5 || clr5) bad++;
         if (k == 3) chk("abort_req_wait", req5, 1);
         if (k == 8) chk("abort_req_idle", req5, 0);
         if (k == 4) bus_idle();
      end
      chk("abort_no_ack", bad, 0);
      tick(); tick();

      // Reset asserted while in ACK
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      chk("rstack_pre_dtack", dtack_n2, 0);
      rst_n = 1'b0;
      bus_idle();
      #1;
      chk("rstack_dtack_n", dtack_n2, 1);
      chk("rstack_req", req2, 0);
      chk("rstack_dtack_w0", dtack_n0, 1);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();

      // Back-to-back: AS negated for a single clock between cycles
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1;
      clr_cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (clr2) clr_cnt++;
         exp_lo = (k >= 5 && k <= 7) || (k >= 12);
         chk("b2b_dtack_w2", dtack_n2, exp_lo ? 0 : 1);
         if (k == 5) as_n = 1'b1;
         if (k == 6) as_n = 1'b0;
      end
      chk("b2b_clr_count", clr_cnt, 2);
      bus_idle();
      for (int k = 0; k < 5; k++) tick();

      // Interrupt-acknowledge function code
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1; fc = 3'b111;
      clr_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (clr2) clr_cnt++;
         exp_lo = (k >= 5 && k <= 9);
`ifdef DTACK_RESPONDER_VPA_EN
         chk("iack_vpa_n", vpa2, exp_lo ? 0 : 1);
         chk("iack_dtack_n", dtack_n2, 1);
`else
         chk("iack_vpa_n", vpa2, 1);
         chk("iack_dtack_n", dtack_n2, exp_lo ? 0 : 1);
`endif
         if (k == 7) bus_idle();
      end
      chk("iack_clr_count", clr_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dtack_responder.md
Name: dtack_responder

Overview:
- 68000-side bus responder; the terminating end of the bus cycle that the bus-error watchdog monitors.
- Detects a selected asynchronous bus cycle (AS/DS strobes, external chip select), inserts programmable wait states, and asserts DTACK.
- On each normal termination, pulses the watchdog clear so the watchdog does not raise BERR.
- Unselected or aborted cycles are never acknowledged; the watchdog then times them out.

Parameters:
- WAIT_CYCLES, 2, wait states inserted between cycle detection and DTACK assertion (0..2^CNT_W-1).
- CNT_W, 4, wait-state counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- as_n  input  1  68000 address strobe, asynchronous, active-low.
- uds_n  input  1  upper data strobe, asynchronous, active-low.
- lds_n  input  1  lower data strobe, asynchronous, active-low.
- rw  input  1  1 = read, 0 = write; sampled at cycle start.
- sel  input  1  address-decode chip select for this responder, active-high.
- fc  input  3  68000 function code; used only with the optional feature.
- dtack_n  output  1  data transfer acknowledge, active-low.
- clr  output  1  one-clock pulse to the watchdog clear input.
- dev_req  output  1  device access strobe, high while a cycle is owned.
- dev_we  output  1  latched write enable (~rw).
- dev_be  output  2  latched byte enables {~uds_n, ~lds_n}.
- vpa_n  output  1  valid peripheral address; tied high when the optional feature is compiled out.

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, dtack_n=1, vpa_n=1, clr=0, dev_req=0, dev_we=0, dev_be=2'b00, synchroniser flops at 1.
- Synchronisation: as_n, uds_n and lds_n each pass through 2 flops. All decisions use the synchronised values (as_s, uds_s, lds_s). sel, rw and fc are sampled in the same cycle the start condition is seen.
- Start condition: as_s==0 && (uds_s==0 || lds_s==0) && sel==1. Writes therefore wait for DS, which arrives after AS.
- IDLE
  - On start: latch dev_we, dev_be and counter=0.
  - If WAIT_CYCLES==0, go to ACK; otherwise go to WAIT.
  - If as_s==0 but sel==0, remain in IDLE and never acknowledge.
- WAIT
  - dev_req=1; counter increments each clock.
  - When counter==WAIT_CYCLES-1, go to ACK.
  - If as_s returns to 1 (abort), go to IDLE with no DTACK and no clr.
- ACK
  - dtack_n=0 registered, dev_req=1.
  - clr=1 for exactly the first ACK clock.
  - Stay in ACK while as_s==0; when as_s==1, go to RELEASE.
- RELEASE: dtack_n=1, dev_req=0, one clock, then IDLE. This guarantees DTACK is negated before the next cycle can start.
- Latency, as_n low to dtack_n low: 2 (sync) + 1 + WAIT_CYCLES clocks.
- Back-to-back cycles: a new start is accepted only from IDLE. The minimum gap is the RELEASE clock.
- Counter saturates and never wraps. WAIT_CYCLES >= 2^CNT_W is a configuration error, flagged by a simulation-only check at elaboration.
- sel dropping mid-cycle is ignored; ownership is decided at start.
- Reset asserted mid-cycle: all outputs return to reset values immediately.

Optional Feature:
- Macro: DTACK_RESPONDER_VPA_EN.
- Defined: when fc==3'b111 at start (interrupt acknowledge), the cycle follows the same FSM but drives vpa_n=0 instead of dtack_n; dtack_n stays 1. clr still pulses in the first ACK clock, and vpa_n is released with dtack_n timing.
- Undefined: fc is ignored and vpa_n is constant 1.

Decomposition:
- Shared package (f68k_bus_pkg):
  - state encoding constants: IDLE, WAIT, ACK, RELEASE.
  - FC_INTACK = 3'b111.
  - strobe polarity constants.
- Sub-module: sync2, a 2-flop synchroniser with async active-low reset and reset value 1, instantiated 3 times. It is shareable with the watchdog side.

Test Plan:
- Read, WAIT_CYCLES=2, sel=1, as_n/uds_n/lds_n low at t0 -> dtack_n low at clock 5 after the edge; clr high exactly 1 clock; dev_be=2'b11, dev_we=0; dtack_n high 1 clock after as_n synchronised high.
- Write with lds_n only, DS asserted 2 clocks after AS -> no start until DS synchronised; dev_we=1, dev_be=2'b01; exactly one clr pulse.
- sel=0 cycle held 300 clocks -> dtack_n, clr and dev_req stay at idle values throughout (watchdog times out).
- Abort: as_n deasserted during WAIT with WAIT_CYCLES=5 -> back to IDLE, no dtack_n, no clr.
- Reset: rst_n pulsed low while in ACK -> dtack_n=1 and dev_req=0 immediately. Also run back-to-back cycles and WAIT_CYCLES=0 (dtack_n low 3 clocks after as_n).
- With DTACK_RESPONDER_VPA_EN defined, fc=3'b111 -> vpa_n low, dtack_n stays 1, clr pulses once. Without the macro, vpa_n stays 1.
